// File: rtl/multi_lane_checker_pkg.sv
// Shared constants and helpers for the multi-lane behavioural-vs-structural checker.
// Provides default widths, the lane-result encoding and the lane-index width helper.
package checker_pkg;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_TIME_WIDTH = 16;

  // Per-lane compare result; both error bits may be set together.
  localparam logic [1:0] MATCH     = 2'b00;
  localparam logic [1:0] DATA_ERR  = 2'b01;
  localparam logic [1:0] VALID_ERR = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int chan_w(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/multi_lane_checker_if.sv
// Lane bus carrying data and valids from the behavioural (_c) and structural (_e) models.
// The models drive through the master modport; the checker listens on the slave modport.
interface multi_lane_checker_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8
);

  logic [CHANNELS*DATA_WIDTH-1:0] data_out_c;
  logic [CHANNELS*DATA_WIDTH-1:0] data_out_e;
  logic [CHANNELS-1:0]            valid_out_c;
  logic [CHANNELS-1:0]            valid_out_e;

  modport master (
    output data_out_c,
    output data_out_e,
    output valid_out_c,
    output valid_out_e
  );

  modport slave (
    input data_out_c,
    input data_out_e,
    input valid_out_c,
    input valid_out_e
  );

endinterface

// File: rtl/multi_lane_checker_lane.sv
// One compared lane: input registers, valid/data compare, saturating error counter, sticky flag.
// lane_err is combinational from the registered inputs so the top can capture in the same cycle.
module checker_lane
  import checker_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int QUALIFY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_c,
  input  logic [DATA_WIDTH-1:0] data_e,
  input  logic                  valid_c,
  input  logic                  valid_e,
  output logic                  check_data,
  output logic                  check_valid,
  output logic                  sticky,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  lane_err,
  output logic [DATA_WIDTH-1:0] data_c_q,
  output logic [DATA_WIDTH-1:0] data_e_q
);

  logic [DATA_WIDTH-1:0] data_c_r;
  logic [DATA_WIDTH-1:0] data_e_r;
  logic                  valid_c_r;
  logic                  valid_e_r;
  logic [1:0]            result;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_c_r  <= '0;
      data_e_r  <= '0;
      valid_c_r <= 1'b0;
      valid_e_r <= 1'b0;
    end else begin
      data_c_r  <= data_c;
      data_e_r  <= data_e;
      valid_c_r <= valid_c;
      valid_e_r <= valid_e;
    end
  end

  always_comb begin
    result = MATCH;
    if (valid_c_r != valid_e_r) result = result | VALID_ERR;
    if ((data_c_r != data_e_r) && ((QUALIFY == 0) || (valid_c_r && valid_e_r)))
      result = result | DATA_ERR;
  end

  assign lane_err = enable && (result != MATCH);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      check_data  <= 1'b1;
      check_valid <= 1'b1;
    end else begin
      check_data  <= (result & DATA_ERR) == MATCH;
      check_valid <= (result & VALID_ERR) == MATCH;
    end
  end

  // Counts error cycles, not error kinds: a cycle failing both checks adds one.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_count <= '0;
      sticky    <= 1'b0;
    end else if (lane_err) begin
      sticky <= 1'b1;
      if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
    end
  end

  assign data_c_q = data_c_r;
  assign data_e_q = data_e_r;

endmodule

// File: rtl/multi_lane_checker.sv
// Multi-lane checker top: per-lane compare instances, cycle counter and first-mismatch capture.
// Optional CHECKER_SKEW_EN inserts a SKEW-deep delay line on the _e path.
module multi_lane_checker
  import checker_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int QUALIFY    = 1,
  parameter int SKEW       = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            clear,
  multi_lane_checker_if.slave             lanes,
  output logic [CHANNELS-1:0]             check_data_out,
  output logic [CHANNELS-1:0]             check_valid,
  output logic [CHANNELS-1:0]             mismatch_sticky,
  output logic [CHANNELS*CNT_WIDTH-1:0]   err_count,
  output logic                            first_err_valid,
  output logic [chan_w(CHANNELS)-1:0]     first_err_chan,
  output logic [TIME_WIDTH-1:0]           first_err_time,
  output logic [DATA_WIDTH-1:0]           first_err_data_c,
  output logic [DATA_WIDTH-1:0]           first_err_data_e
);

  localparam int CHAN_W = chan_w(CHANNELS);

  logic [CHANNELS*DATA_WIDTH-1:0] data_e_in;
  logic [CHANNELS-1:0]            valid_e_in;
  logic [CHANNELS-1:0]            lane_err;
  logic [DATA_WIDTH-1:0]          lane_data_c [CHANNELS];
  logic [DATA_WIDTH-1:0]          lane_data_e [CHANNELS];
  logic [CHAN_W-1:0]              sel_chan;
  logic [DATA_WIDTH-1:0]          sel_data_c;
  logic [DATA_WIDTH-1:0]          sel_data_e;
  logic [TIME_WIDTH-1:0]          cycle_cnt;

`ifdef CHECKER_SKEW_EN
  if (SKEW == 0) begin : g_no_skew
    assign data_e_in  = lanes.data_out_e;
    assign valid_e_in = lanes.valid_out_e;
  end else begin : g_skew
    logic [CHANNELS*DATA_WIDTH-1:0] data_dly  [SKEW];
    logic [CHANNELS-1:0]            valid_dly [SKEW];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < SKEW; s++) begin
          data_dly[s]  <= '0;
          valid_dly[s] <= '0;
        end
      end else begin
        data_dly[0]  <= lanes.data_out_e;
        valid_dly[0] <= lanes.valid_out_e;
        for (int s = 1; s < SKEW; s++) begin
          data_dly[s]  <= data_dly[s-1];
          valid_dly[s] <= valid_dly[s-1];
        end
      end
    end

    assign data_e_in  = data_dly[SKEW-1];
    assign valid_e_in = valid_dly[SKEW-1];
  end
`else
  // Without the delay line SKEW has no effect; this empty block only keeps it referenced.
  if (SKEW != 0) begin : g_skew_ignored
  end
  assign data_e_in  = lanes.data_out_e;
  assign valid_e_in = lanes.valid_out_e;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    checker_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .QUALIFY    (QUALIFY)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .clear       (clear),
      .data_c      (lanes.data_out_c[i*DATA_WIDTH +: DATA_WIDTH]),
      .data_e      (data_e_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid_c     (lanes.valid_out_c[i]),
      .valid_e     (valid_e_in[i]),
      .check_data  (check_data_out[i]),
      .check_valid (check_valid[i]),
      .sticky      (mismatch_sticky[i]),
      .err_count   (err_count[i*CNT_WIDTH +: CNT_WIDTH]),
      .lane_err    (lane_err[i]),
      .data_c_q    (lane_data_c[i]),
      .data_e_q    (lane_data_e[i])
    );
  end

  // Scan from the top so the lowest failing lane is the one left selected.
  always_comb begin
    sel_chan   = '0;
    sel_data_c = '0;
    sel_data_e = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (lane_err[i]) begin
        sel_chan   = CHAN_W'(i);
        sel_data_c = lane_data_c[i];
        sel_data_e = lane_data_e[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + TIME_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      first_err_valid  <= 1'b0;
      first_err_chan   <= '0;
      first_err_time   <= '0;
      first_err_data_c <= '0;
      first_err_data_e <= '0;
    end else if (!first_err_valid && (|lane_err)) begin
      first_err_valid  <= 1'b1;
      first_err_chan   <= sel_chan;
      first_err_time   <= cycle_cnt;
      first_err_data_c <= sel_data_c;
      first_err_data_e <= sel_data_e;
    end
  end

endmodule

// File: tb/tb_multi_lane_checker.sv
// Directed bench for multi_lane_checker: four instances (default, CNT_WIDTH=4, QUALIFY=0, SKEW=2)
// share one lane bus; expectations depend on CHECKER_SKEW_EN for the skew instance.
module tb_multi_lane_checker;

  logic clk;
  logic reset;
  logic enable;
  logic clear;

  int n_vec = 0;
  int n_err = 0;

  multi_lane_checker_if #(.CHANNELS(4), .DATA_WIDTH(8)) bus ();

  logic [3:0]  m_cd, m_cv, m_st;
  logic [31:0] m_ec;
  logic        m_fv;
  logic [1:0]  m_fc;
  logic [15:0] m_ft;
  logic [7:0]  m_fdc, m_fde;

  logic [3:0]  s_cd, s_cv, s_st;
  logic [15:0] s_ec;
  logic        s_fv;
  logic [1:0]  s_fc;
  logic [15:0] s_ft;
  logic [7:0]  s_fdc, s_fde;

  logic [3:0]  q_cd, q_cv, q_st;
  logic [31:0] q_ec;
  logic        q_fv;
  logic [1:0]  q_fc;
  logic [15:0] q_ft;
  logic [7:0]  q_fdc, q_fde;

  logic [3:0]  k_cd, k_cv, k_st;
  logic [31:0] k_ec;
  logic        k_fv;
  logic [1:0]  k_fc;
  logic [15:0] k_ft;
  logic [7:0]  k_fdc, k_fde;

  multi_lane_checker dut_main (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .lanes(bus.slave),
    .check_data_out(m_cd), .check_valid(m_cv), .mismatch_sticky(m_st), .err_count(m_ec),
    .first_err_valid(m_fv), .first_err_chan(m_fc), .first_err_time(m_ft),
    .first_err_data_c(m_fdc), .first_err_data_e(m_fde)
  );

  multi_lane_checker #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .lanes(bus.slave),
    .check_data_out(s_cd), .check_valid(s_cv), .mismatch_sticky(s_st), .err_count(s_ec),
    .first_err_valid(s_fv), .first_err_chan(s_fc), .first_err_time(s_ft),
    .first_err_data_c(s_fdc), .first_err_data_e(s_fde)
  );

  multi_lane_checker #(.QUALIFY(0)) dut_q0 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .lanes(bus.slave),
    .check_data_out(q_cd), .check_valid(q_cv), .mismatch_sticky(q_st), .err_count(q_ec),
    .first_err_valid(q_fv), .first_err_chan(q_fc), .first_err_time(q_ft),
    .first_err_data_c(q_fdc), .first_err_data_e(q_fde)
  );

  multi_lane_checker #(.SKEW(2)) dut_skew (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .lanes(bus.slave),
    .check_data_out(k_cd), .check_valid(k_cv), .mismatch_sticky(k_st), .err_count(k_ec),
    .first_err_valid(k_fv), .first_err_chan(k_fc), .first_err_time(k_ft),
    .first_err_data_c(k_fdc), .first_err_data_e(k_fde)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_bus();
    bus.data_out_c  = '0;
    bus.data_out_e  = '0;
    bus.valid_out_c = '0;
    bus.valid_out_e = '0;
  endtask

  task automatic set_lane(input int l, input logic [7:0] dc, input logic [7:0] de,
                          input logic vc, input logic ve);
    bus.data_out_c[l*8 +: 8] = dc;
    bus.data_out_e[l*8 +: 8] = de;
    bus.valid_out_c[l]       = vc;
    bus.valid_out_e[l]       = ve;
  endtask

  // Leaves reset low just after an edge: the next edge is cycle 1.
  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    clear  = 1'b0;
    zero_bus();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (m_cd !== 4'hF) begin n_err++; $display("FAIL reset_check_data got=%h exp=%h", m_cd, 4'hF); end
    n_vec++; if (m_cv !== 4'hF) begin n_err++; $display("FAIL reset_check_valid got=%h exp=%h", m_cv, 4'hF); end
    n_vec++; if (m_ec !== 32'h0) begin n_err++; $display("FAIL reset_err_count got=%h exp=%h", m_ec, 32'h0); end
    n_vec++; if (m_st !== 4'h0) begin n_err++; $display("FAIL reset_sticky got=%h exp=%h", m_st, 4'h0); end
    n_vec++; if (m_fv !== 1'b0) begin n_err++; $display("FAIL reset_first_valid got=%b exp=0", m_fv); end
    n_vec++; if (m_ft !== 16'h0) begin n_err++; $display("FAIL reset_first_time got=%h exp=0", m_ft); end
    // reset mid-stream: stage-1 mismatch must be wiped
    set_lane(0, 8'h12, 8'h34, 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    zero_bus();
    tick();
    n_vec++; if (m_cd !== 4'hF) begin n_err++; $display("FAIL midreset_check_data got=%h exp=%h", m_cd, 4'hF); end
    n_vec++; if (m_ec !== 32'h0) begin n_err++; $display("FAIL midreset_err_count got=%h exp=%h", m_ec, 32'h0); end
    n_vec++; if (m_fv !== 1'b0) begin n_err++; $display("FAIL midreset_first_valid got=%b exp=0", m_fv); end
  endtask

  task automatic test_random_match();
    logic [7:0] d;
    logic       v;
    do_reset();
    for (int cyc = 1; cyc <= 100; cyc++) begin
      for (int l = 0; l < 4; l++) begin
        d = 8'($urandom);
        v = 1'($urandom);
        set_lane(l, d, d, v, v);
      end
      tick();
      n_vec++; if (m_cd !== 4'hF) begin n_err++; $display("FAIL random_check_data cyc=%0d got=%h exp=%h", cyc, m_cd, 4'hF); end
      n_vec++; if (m_cv !== 4'hF) begin n_err++; $display("FAIL random_check_valid cyc=%0d got=%h exp=%h", cyc, m_cv, 4'hF); end
    end
    n_vec++; if (m_ec !== 32'h0) begin n_err++; $display("FAIL random_err_count got=%h exp=%h", m_ec, 32'h0); end
    n_vec++; if (m_fv !== 1'b0) begin n_err++; $display("FAIL random_first_valid got=%b exp=0", m_fv); end
    n_vec++; if (q_ec !== 32'h0) begin n_err++; $display("FAIL random_q0_err_count got=%h exp=%h", q_ec, 32'h0); end
  endtask

  task automatic test_first_capture();
    do_reset();
    for (int cyc = 1; cyc <= 22; cyc++) begin
      for (int l = 0; l < 4; l++) set_lane(l, 8'(cyc*3 + l), 8'(cyc*3 + l), 1'b1, 1'b1);
      if (cyc == 20) set_lane(2, 8'hA5, 8'hA4, 1'b1, 1'b1);
      tick();
      if (cyc == 21) begin
        n_vec++; if (m_cd !== 4'b1011) begin n_err++; $display("FAIL cap_check_data got=%b exp=1011", m_cd); end
        n_vec++; if (m_cv !== 4'hF) begin n_err++; $display("FAIL cap_check_valid got=%h exp=F", m_cv); end
        n_vec++; if (m_ec !== 32'h0001_0000) begin n_err++; $display("FAIL cap_err_count got=%h exp=00010000", m_ec); end
        n_vec++; if (m_fv !== 1'b1) begin n_err++; $display("FAIL cap_first_valid got=%b exp=1", m_fv); end
        n_vec++; if (m_fc !== 2'd2) begin n_err++; $display("FAIL cap_first_chan got=%0d exp=2", m_fc); end
        n_vec++; if (m_ft !== 16'd20) begin n_err++; $display("FAIL cap_first_time got=%0d exp=20", m_ft); end
        n_vec++; if (m_fdc !== 8'hA5) begin n_err++; $display("FAIL cap_first_data_c got=%h exp=A5", m_fdc); end
        n_vec++; if (m_fde !== 8'hA4) begin n_err++; $display("FAIL cap_first_data_e got=%h exp=A4", m_fde); end
      end
      if (cyc == 22) begin
        n_vec++; if (m_cd !== 4'hF) begin n_err++; $display("FAIL cap_recover_check_data got=%h exp=F", m_cd); end
        n_vec++; if (m_st !== 4'b0100) begin n_err++; $display("FAIL cap_sticky got=%b exp=0100", m_st); end
      end
    end
  endtask

  task automatic test_multi_lane();
    do_reset();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      zero_bus();
      bus.valid_out_c = 4'hF;
      bus.valid_out_e = 4'hF;
      if (cyc == 3) begin
        set_lane(1, 8'h11, 8'h12, 1'b1, 1'b1);
        set_lane(3, 8'h33, 8'h30, 1'b1, 1'b1);
      end
      if (cyc == 5) set_lane(0, 8'h40, 8'h41, 1'b1, 1'b1);
      tick();
      if (cyc == 4) begin
        n_vec++; if (m_cd !== 4'b0101) begin n_err++; $display("FAIL multi_check_data got=%b exp=0101", m_cd); end
        n_vec++; if (m_fc !== 2'd1) begin n_err++; $display("FAIL multi_first_chan got=%0d exp=1", m_fc); end
        n_vec++; if (m_ft !== 16'd3) begin n_err++; $display("FAIL multi_first_time got=%0d exp=3", m_ft); end
        n_vec++; if (m_fdc !== 8'h11) begin n_err++; $display("FAIL multi_first_data_c got=%h exp=11", m_fdc); end
        n_vec++; if (m_fde !== 8'h12) begin n_err++; $display("FAIL multi_first_data_e got=%h exp=12", m_fde); end
      end
      if (cyc == 6) begin
        n_vec++; if (m_fc !== 2'd1) begin n_err++; $display("FAIL multi_hold_chan got=%0d exp=1", m_fc); end
        n_vec++; if (m_ft !== 16'd3) begin n_err++; $display("FAIL multi_hold_time got=%0d exp=3", m_ft); end
        n_vec++; if (m_st !== 4'b1011) begin n_err++; $display("FAIL multi_sticky got=%b exp=1011", m_st); end
        n_vec++; if (m_ec !== 32'h0100_0101) begin n_err++; $display("FAIL multi_err_count got=%h exp=01000101", m_ec); end
      end
    end
  endtask

  task automatic test_valid_mismatch();
    do_reset();
    set_lane(0, 8'h55, 8'h66, 1'b1, 1'b0);
    set_lane(1, 8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    zero_bus();
    tick();
    n_vec++; if (m_cv !== 4'b1110) begin n_err++; $display("FAIL vmis_check_valid got=%b exp=1110", m_cv); end
    n_vec++; if (m_cd !== 4'hF) begin n_err++; $display("FAIL vmis_check_data got=%b exp=1111", m_cd); end
    n_vec++; if (m_ec !== 32'h0000_0001) begin n_err++; $display("FAIL vmis_err_count got=%h exp=00000001", m_ec); end
    n_vec++; if (m_st !== 4'b0001) begin n_err++; $display("FAIL vmis_sticky got=%b exp=0001", m_st); end
    n_vec++; if (q_cv !== 4'b1110) begin n_err++; $display("FAIL q0_check_valid got=%b exp=1110", q_cv); end
    n_vec++; if (q_cd !== 4'b1100) begin n_err++; $display("FAIL q0_check_data got=%b exp=1100", q_cd); end
    n_vec++; if (q_ec !== 32'h0000_0101) begin n_err++; $display("FAIL q0_err_count got=%h exp=00000101", q_ec); end
    n_vec++; if (q_st !== 4'b0011) begin n_err++; $display("FAIL q0_sticky got=%b exp=0011", q_st); end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    set_lane(2, 8'h77, 8'h78, 1'b1, 1'b1);
    tick();
    tick();
    n_vec++; if (m_cd !== 4'hF) begin n_err++; $display("FAIL dis_check_data got=%b exp=1111", m_cd); end
    n_vec++; if (m_cv !== 4'hF) begin n_err++; $display("FAIL dis_check_valid got=%b exp=1111", m_cv); end
    n_vec++; if (m_ec !== 32'h0) begin n_err++; $display("FAIL dis_err_count got=%h exp=0", m_ec); end
    n_vec++; if (m_fv !== 1'b0) begin n_err++; $display("FAIL dis_first_valid got=%b exp=0", m_fv); end
    enable = 1'b1;
    tick();
    n_vec++; if (m_cd !== 4'b1011) begin n_err++; $display("FAIL en_check_data got=%b exp=1011", m_cd); end
    n_vec++; if (m_ec !== 32'h0001_0000) begin n_err++; $display("FAIL en_err_count got=%h exp=00010000", m_ec); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int cyc = 1; cyc <= 21; cyc++) begin
      set_lane(0, 8'h10, 8'h20, 1'b1, 1'b1);
      tick();
      if (cyc == 15) begin
        n_vec++; if (s_ec[3:0] !== 4'd14) begin n_err++; $display("FAIL sat_count_14 got=%0d exp=14", s_ec[3:0]); end
      end
      if (cyc == 16) begin
        n_vec++; if (s_ec[3:0] !== 4'd15) begin n_err++; $display("FAIL sat_count_15 got=%0d exp=15", s_ec[3:0]); end
      end
    end
    n_vec++; if (s_ec !== 16'h000F) begin n_err++; $display("FAIL sat_hold got=%h exp=000F", s_ec); end
    clear = 1'b1;
    zero_bus();
    tick();
    n_vec++; if (s_ec !== 16'h0) begin n_err++; $display("FAIL clr_err_count got=%h exp=0", s_ec); end
    n_vec++; if (s_st !== 4'h0) begin n_err++; $display("FAIL clr_sticky got=%b exp=0000", s_st); end
    n_vec++; if (s_fv !== 1'b0) begin n_err++; $display("FAIL clr_first_valid got=%b exp=0", s_fv); end
    n_vec++; if (s_cd !== 4'b1110) begin n_err++; $display("FAIL clr_check_data got=%b exp=1110", s_cd); end
    clear = 1'b0;
    tick();
    n_vec++; if (s_ec !== 16'h0) begin n_err++; $display("FAIL postclr_err_count got=%h exp=0", s_ec); end
    n_vec++; if (s_cd !== 4'hF) begin n_err++; $display("FAIL postclr_check_data got=%b exp=1111", s_cd); end
  endtask

  function automatic logic [7:0] skew_data(input int k, input int l);
    return (k <= 0) ? 8'h00 : 8'(k*7 + 1 + l*16);
  endfunction

  task automatic test_skew();
    do_reset();
    for (int n = 1; n <= 11; n++) begin
      for (int l = 0; l < 4; l++)
        set_lane(l, skew_data(n - 2, l), skew_data(n, l), (n >= 3), 1'b1);
      tick();
    end
`ifdef CHECKER_SKEW_EN
    n_vec++; if (k_ec !== 32'h0) begin n_err++; $display("FAIL skew_err_count got=%h exp=0", k_ec); end
    n_vec++; if (k_st !== 4'h0) begin n_err++; $display("FAIL skew_sticky got=%b exp=0000", k_st); end
    n_vec++; if (k_cd !== 4'hF) begin n_err++; $display("FAIL skew_check_data got=%b exp=1111", k_cd); end
    n_vec++; if (k_fv !== 1'b0) begin n_err++; $display("FAIL skew_first_valid got=%b exp=0", k_fv); end
`else
    n_vec++; if (k_ec !== 32'h0A0A_0A0A) begin n_err++; $display("FAIL noskew_err_count got=%h exp=0A0A0A0A", k_ec); end
    n_vec++; if (k_st !== 4'hF) begin n_err++; $display("FAIL noskew_sticky got=%b exp=1111", k_st); end
    n_vec++; if (k_cd !== 4'h0) begin n_err++; $display("FAIL noskew_check_data got=%b exp=0000", k_cd); end
    n_vec++; if (k_ft !== 16'd1) begin n_err++; $display("FAIL noskew_first_time got=%0d exp=1", k_ft); end
`endif
    n_vec++; if (m_ec !== 32'h0A0A_0A0A) begin n_err++; $display("FAIL skew_main_err_count got=%h exp=0A0A0A0A", m_ec); end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    clear  = 1'b0;
    zero_bus();
    test_reset();
    test_random_match();
    test_first_capture();
    test_multi_lane();
    test_valid_mismatch();
    test_enable();
    test_saturation();
    test_skew();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
